// File: rtl/disp_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
// Segment and anode vectors are active low throughout.
package disp_pkg;

    localparam logic [7:0] SEG_OFF      = 8'hFF;
    localparam logic [3:0] NIBBLE_BLANK = 4'hF;

    function automatic logic [7:0] an_onehot_n(
        input logic [2:0]  idx,
        input int unsigned n
    );
        logic [7:0] v;
        v = 8'hFF;
        if (32'(idx) < n) v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/nibble_encoder.sv
// BCD nibble to active-low {dp,g..a} segment pattern.
// Codes 10..15 (including the blank code) light nothing.
module nibble_encoder
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nib)
            4'd0:    o_seg = 8'b1_1000000;
            4'd1:    o_seg = 8'b1_1111001;
            4'd2:    o_seg = 8'b1_0100100;
            4'd3:    o_seg = 8'b1_0110000;
            4'd4:    o_seg = 8'b1_0011001;
            4'd5:    o_seg = 8'b1_0010010;
            4'd6:    o_seg = 8'b1_0000010;
            4'd7:    o_seg = 8'b1_1111000;
            4'd8:    o_seg = 8'b1_0000000;
            4'd9:    o_seg = 8'b1_0010000;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller
// with per-slot anti-ghost blanking, frame snapshots and leading-zero blanking.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    logic [CW-1:0]                r_cnt;
    logic [IW-1:0]                r_idx;
    logic [N_DIGITS-1:0][3:0]     r_shadow;
    logic [N_DIGITS-1:0]          r_dp;
    logic                         r_primed;
    logic [7:0]                   r_seg;
    logic [N_DIGITS-1:0]          r_an;
    logic                         r_tick;

    logic                         w_slot_end;
    logic                         w_load;
    logic                         w_off;
    logic                         w_lz;
    logic [N_DIGITS-1:0]          w_zero_up;
    logic [3:0]                   w_nib;
    logic [7:0]                   w_enc;
    logic [7:0]                   w_an_full;
    logic [7:0]                   w_seg_nxt;
    logic [N_DIGITS-1:0]          w_an_nxt;
    logic                         w_unused;

    assign w_slot_end = en && (r_cnt == CNT_LAST);
    assign w_load     = (en && !r_primed) ||
                        (w_slot_end && (r_idx == IDX_LAST));
    assign w_off      = !en || (r_cnt < CNT_BLANK);

    // w_zero_up[k]: digit k and every digit above it are zero
    always_comb begin
        logic v_acc;
        v_acc     = 1'b1;
        w_zero_up = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            v_acc        = v_acc && (r_shadow[k] == 4'd0);
            w_zero_up[k] = v_acc;
        end
    end

    assign w_lz  = lz_blank && (r_idx != '0) && w_zero_up[r_idx];
    assign w_nib = w_lz ? NIBBLE_BLANK : r_shadow[r_idx];

    nibble_encoder u_enc (
        .i_nib (w_nib),
        .o_seg (w_enc)
    );

    assign w_an_full = an_onehot_n(3'(r_idx), N_DIGITS);
    assign w_unused  = ^{w_an_full, w_enc[7]};

    always_comb begin
        w_seg_nxt = SEG_OFF;
        w_an_nxt  = '1;
        if (!w_off) begin
            w_seg_nxt = {~r_dp[r_idx], w_enc[6:0]};
            w_an_nxt  = w_an_full[N_DIGITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (en) begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_dp     <= '0;
            r_primed <= 1'b0;
        end else if (w_load) begin
            r_shadow <= digits_in;
            r_dp     <= dp_in;
            r_primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= SEG_OFF;
            r_an   <= '1;
            r_tick <= 1'b0;
        end else begin
            r_seg  <= w_seg_nxt;
            r_an   <= w_an_nxt;
            r_tick <= w_load;
        end
    end

    assign seg_out    = r_seg;
    assign an_out     = r_an;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame/slot-level
// reference model (N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2).
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BL = 2;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // Model: position within the frame counted in enabled cycles
    int         m_pos;
    bit         m_primed;
    int         m_snap [N];
    bit         m_dp   [N];
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_tick;

    task automatic model_reset();
        m_pos    = 0;
        m_primed = 0;
        for (int k = 0; k < N; k++) begin
            m_snap[k] = 0;
            m_dp[k]   = 0;
        end
        e_seg  = 8'hFF;
        e_an   = 4'hF;
        e_tick = 1'b0;
    endtask

    task automatic model_step();
        int         ph;
        int         sl;
        bit         hz;
        bit         load;
        logic [6:0] s7;
        ph = m_pos % SD;
        sl = (m_pos / SD) % N;
        if (!en || ph < BL) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end else begin
            hz = 1;
            for (int j = sl; j < N; j++)
                if (m_snap[j] != 0) hz = 0;
            if ((lz_blank && sl != 0 && hz) || m_snap[sl] > 9)
                s7 = 7'h7F;
            else
                s7 = SEG_TAB[m_snap[sl]];
            e_seg = {~m_dp[sl], s7};
            e_an  = 4'hF ^ (4'b0001 << sl);
        end
        load   = en && (!m_primed || (ph == SD - 1 && sl == N - 1));
        e_tick = load;
        if (load) begin
            m_primed = 1;
            for (int k = 0; k < N; k++) begin
                m_snap[k] = int'(digits_in[4*k +: 4]);
                m_dp[k]   = dp_in[k];
            end
        end
        if (en) m_pos = (m_pos + 1) % (SD * N);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("seg", 32'(seg_out), 32'(e_seg));
        chk("an", 32'(an_out), 32'(e_an));
        chk("tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_off(input string tag);
        chk({tag, "_seg"}, 32'(seg_out), 32'hFF);
        chk({tag, "_an"}, 32'(an_out), 32'hF);
        chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    // Asynchronous reset pulse in the middle of the high clock phase
    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_off("rst_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_off("rst_hold");
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom % 8 < 4) ? 4'd0 : 4'($urandom % 16);
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        lz_blank  = 1'b0;
        model_reset();
        #12;
        check_off("reset");
        @(negedge clk);
        rst_n = 1'b1;

        digits_in = 16'h1234;
        en        = 1'b1;
        run(2 * N * SD);

        digits_in = 16'h0050;
        lz_blank  = 1'b1;
        run(2 * N * SD);

        digits_in = 16'h0000;
        run(2 * N * SD);

        lz_blank  = 1'b0;
        dp_in     = 4'b0010;
        digits_in = 16'h4321;
        run(N * SD + 12);
        digits_in = 16'h9876;
        run(2 * N * SD);

        for (int i = 0; i < 80; i++) begin
            en = (i % 13) >= 3;
            cycle();
        end
        en = 1'b1;

        pulse_reset();
        run(N * SD + 4);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 100 < 8)  digits_in = rand_digits();
            if ($urandom % 100 < 8)  dp_in     = 4'($urandom);
            if ($urandom % 100 < 3)  lz_blank  = ~lz_blank;
            en = ($urandom % 100) < 88;
            if ($urandom % 600 == 0) pulse_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
